video_sync_delay_line: RTL



---
 rtl/video_sync_delay_line_if.sv | 28 ++
 rtl/video_sync_delay_line.sv | 126 ++++++++++++
 2 files changed

// File: rtl/video_sync_delay_line_if.sv
// Bundle of data and configuration signals for the video sync delay line.
// The master side drives din and the configuration request.
// The slave side (the delay line) returns the delayed vector and status.
interface video_sync_delay_line_if #(
  parameter int DATA_W  = 3,
  parameter int ROW_W   = 8,
  parameter int COL_W   = 12,
  parameter int DEPTH_W = 16
) ();
  logic [DATA_W-1:0]  din;
  logic               cfg_load;
  logic [ROW_W-1:0]   delay_rows;
  logic [COL_W-1:0]   delay_cols;
  logic [DATA_W-1:0]  dout;
  logic               dout_valid;
  logic [DEPTH_W-1:0] cur_depth;
  logic               cfg_err;

  modport master (
    output din, cfg_load, delay_rows, delay_cols,
    input  dout, dout_valid, cur_depth, cfg_err
  );

  modport slave (
    input  din, cfg_load, delay_rows, delay_cols,
    output dout, dout_valid, cur_depth, cfg_err
  );
endinterface

// File: rtl/video_sync_delay_line.sv
// Runtime-reconfigurable delay line for video timing/sideband bits.
// Delays din by D = rows*LINE_W + cols cycles using a circular buffer in
// inferred single-clock block RAM. Output is suppressed (FILL) until the
// buffer holds D fresh samples for the current depth, then runs (RUN).
module video_sync_delay_line #(
  parameter int DATA_W    = 3,
  parameter int LINE_W    = 1650,
  parameter int MAX_DEPTH = 32768,
  parameter int DEF_ROWS  = 15,
  parameter int DEF_COLS  = 15,
  parameter int ROW_W     = 8,
  parameter int COL_W     = 12
) (
  input logic                    clk,
  input logic                    rst_n,
  video_sync_delay_line_if.slave bus
);

  localparam int AW        = $clog2(MAX_DEPTH);
  localparam int DW        = AW + 1;
  localparam int LW        = $clog2(LINE_W + 1);
  localparam int PROD_W    = ROW_W + LW;
  localparam int SUM_W     = ((PROD_W > COL_W) ? PROD_W : COL_W) + 1;
  localparam int REQ_W     = (SUM_W > DW + 1) ? SUM_W : DW + 1;
  localparam int DEF_REQ   = DEF_ROWS * LINE_W + DEF_COLS;
  localparam int DEF_CLAMP = (DEF_REQ < 2) ? 2 :
                             ((DEF_REQ > MAX_DEPTH) ? MAX_DEPTH : DEF_REQ);
  localparam logic [DW-1:0] DEF_DEPTH = DW'(DEF_CLAMP);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  // Minimum depth is 2: a 1-cycle delay would read the slot being written.
  function automatic logic [DW-1:0] clamp_depth(input logic [REQ_W-1:0] req);
    if (req < REQ_W'(2))
      return DW'(2);
    else if (req > REQ_W'(MAX_DEPTH))
      return DW'(MAX_DEPTH);
    else
      return DW'(req);
  endfunction

  function automatic logic depth_clamped(input logic [REQ_W-1:0] req);
    return (req < REQ_W'(2)) || (req > REQ_W'(MAX_DEPTH));
  endfunction

  state_t             state;
  logic [DW-1:0]      fill_cnt;
  logic [DW-1:0]      cur_depth;
  logic               cfg_err;
  logic               vld_p1;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_addr;
  logic [REQ_W-1:0]   d_req;
  logic               run_nxt;
  logic [DATA_W-1:0]  mem [MAX_DEPTH];
  logic [DATA_W-1:0]  dout_p1;

  // Requested depth at full width so oversized requests clamp instead of wrapping.
  assign d_req = REQ_W'(bus.delay_rows) * REQ_W'(LINE_W) + REQ_W'(bus.delay_cols);

  // Read D-1 behind the write pointer; the read register adds the last cycle.
  assign rd_addr = wr_ptr - AW'(cur_depth - DW'(1));

  // Whether the next cycle is a RUN cycle; drives both valid and the dout mask.
  always_comb begin
    run_nxt = 1'b0;
    if (rst_n && !bus.cfg_load)
      run_nxt = (state == RUN) || (fill_cnt == cur_depth - DW'(1));
  end

  // Control FSM: priming counter, depth configuration and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      fill_cnt  <= '0;
      cur_depth <= DEF_DEPTH;
      cfg_err   <= 1'b0;
      vld_p1    <= 1'b0;
    end else if (bus.cfg_load) begin
      state     <= FILL;
      fill_cnt  <= '0;
      cur_depth <= clamp_depth(d_req);
      cfg_err   <= depth_clamped(d_req);
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= run_nxt;
      case (state)
        FILL: begin
          if (fill_cnt == cur_depth - DW'(1))
            state <= RUN;
          else
            fill_cnt <= fill_cnt + DW'(1);
        end
        RUN:     state <= RUN;
        default: state <= FILL;
      endcase
    end
  end

  // Free-running write pointer; wraps modulo MAX_DEPTH, no back-pressure.
  always_ff @(posedge clk) begin
    if (!rst_n)
      wr_ptr <= '0;
    else
      wr_ptr <= wr_ptr + AW'(1);
  end

  // Stage p0 -> RAM: din is written every cycle, contents never cleared.
  always_ff @(posedge clk) begin
    mem[wr_ptr] <= bus.din;
  end

  // Stage p1: registered RAM read, zeroed whenever the next cycle is not RUN.
  always_ff @(posedge clk) begin
    if (run_nxt)
      dout_p1 <= mem[rd_addr];
    else
      dout_p1 <= '0;
  end

  assign bus.dout       = dout_p1;
  assign bus.dout_valid = vld_p1;
  assign bus.cur_depth  = cur_depth;
  assign bus.cfg_err    = cfg_err;

endmodule
